// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register-access controller.
package i2c_pkg;

  localparam int         DEF_NUM_REGS = 256;
  localparam int         DEF_ADDR_W   = 8;
  localparam logic [7:0] NACK_FILL    = 8'hFF;

  // Access sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WR_COMMIT = 2'd1,
    ST_RD_ISSUE  = 2'd2,
    ST_RD_WAIT   = 2'd3
  } state_e;

  // Whether the next written byte is the register pointer or register data.
  typedef enum logic {
    PH_PTR  = 1'b0,
    PH_DATA = 1'b1
  } phase_e;

endpackage

// File: rtl/i2c_reg_ptr.sv
// Register pointer: loadable, optional increment that wraps at NUM_REGS-1,
// and a flag telling whether the pointer names an implemented register.
module i2c_reg_ptr
  import i2c_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = DEF_ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              inc,
  output logic [ADDR_W-1:0] ptr,
  output logic              valid
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W:0]   NUM_REGS_W = (ADDR_W + 1)'(NUM_REGS);

  logic [ADDR_W-1:0] ptr_q;

  // Pointer register: load has priority over increment.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    if (rst_i) begin
      ptr_q <= '0;
    end else if (load) begin
      ptr_q <= load_val;
    end else if (inc) begin
      ptr_q <= (ptr_q == LAST_ADDR) ? '0 : ptr_q + ADDR_W'(1);
    end
  end

  assign ptr   = ptr_q;
  assign valid = ({1'b0, ptr_q} < NUM_REGS_W);

endmodule

// File: rtl/i2c_reg_access_ctrl.sv
// Turns the I2C slave's byte requests into register-bank reads and writes:
// first byte after address match sets the pointer, later bytes access reg[ptr].
module i2c_reg_access_ctrl
  import i2c_pkg::*;
#(
  parameter int NUM_REGS   = DEF_NUM_REGS,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int RD_TIMEOUT = 15
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_detected_i,
  input  logic              stop_detected_i,
  input  logic              addr_match_i,
  input  logic              rw_bit_i,
  input  logic              wr_req_i,
  input  logic              rd_req_i,
  input  logic [7:0]        i2c_rx_data_i,
  output logic [7:0]        i2c_tx_data_o,
  output logic              wr_allow_o,
  output logic              rd_allow_o,
  input  logic              auto_inc_i,
  output logic [ADDR_W-1:0] reg_addr_o,
  output logic [7:0]        reg_wdata_o,
  output logic              reg_we_o,
  output logic              reg_re_o,
  input  logic [7:0]        reg_rdata_i,
  input  logic              reg_rvalid_i,
  output logic [ADDR_W-1:0] ptr_o,
  output logic              err_o
);

  localparam int CNT_W = $clog2(RD_TIMEOUT + 1);

  state_e            state_q, state_d;
  phase_e            phase_q;
  logic              wr_req_q, rd_req_q;
  logic              bus_evt, wr_evt, rd_evt, rd_timeout;
  logic              ptr_load, ptr_inc, ptr_valid;
  logic [ADDR_W-1:0] ptr;
  logic [CNT_W-1:0]  wait_cnt_q;
  logic [7:0]        wdata_q, tx_data_q;
  logic              wr_allow_q, rd_allow_q, err_q;

  // START/STOP outrank request edges; an edge in the same cycle is lost.
  assign bus_evt    = start_detected_i | stop_detected_i;
  assign wr_evt     = wr_req_i & ~wr_req_q & addr_match_i & ~rw_bit_i & ~bus_evt;
  assign rd_evt     = rd_req_i & ~rd_req_q & addr_match_i &  rw_bit_i & ~bus_evt;
  assign rd_timeout = (wait_cnt_q == CNT_W'(RD_TIMEOUT - 1)) & ~reg_rvalid_i;

  assign ptr_load = (state_q == ST_IDLE) & wr_evt & (phase_q == PH_PTR);
  assign ptr_inc  = auto_inc_i & ~bus_evt &
                    ((state_q == ST_WR_COMMIT) |
                     ((state_q == ST_RD_WAIT) & reg_rvalid_i));

  i2c_reg_ptr #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_reg_ptr (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load     (ptr_load),
    .load_val (i2c_rx_data_i[ADDR_W-1:0]),
    .inc      (ptr_inc),
    .ptr      (ptr),
    .valid    (ptr_valid)
  );

  // Request level history for rising-edge detection.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_req_q <= 1'b0;
      rd_req_q <= 1'b0;
    end else begin
      wr_req_q <= wr_req_i;
      rd_req_q <= rd_req_i;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    if (bus_evt) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (wr_evt && (phase_q == PH_DATA) && ptr_valid) state_d = ST_WR_COMMIT;
          else if (rd_evt && ptr_valid)                    state_d = ST_RD_ISSUE;
        end
        ST_WR_COMMIT: state_d = ST_IDLE;
        ST_RD_ISSUE:  state_d = ST_RD_WAIT;
        ST_RD_WAIT:   if (reg_rvalid_i || rd_timeout) state_d = ST_IDLE;
        default:      state_d = ST_IDLE;
      endcase
    end
  end

  // FSM outputs: single-cycle strobes, suppressed by reset or bus events.
  always_comb begin
    reg_we_o    = 1'b0;
    reg_re_o    = 1'b0;
    reg_wdata_o = '0;
    reg_addr_o  = ptr;
    if (!rst_i && !bus_evt) begin
      unique case (state_q)
        ST_WR_COMMIT: begin
          reg_we_o    = 1'b1;
          reg_wdata_o = wdata_q;
        end
        ST_RD_ISSUE: reg_re_o = 1'b1;
        default: ;
      endcase
    end
  end

  // Phase, handshake, tx data, sticky error and read-wait counter.
  always_ff @(posedge clk_i) begin
    // NOTE: data registers are reset too, because every output must read 0 after reset.
    if (rst_i) begin
      phase_q    <= PH_PTR;
      wdata_q    <= '0;
      tx_data_q  <= '0;
      wr_allow_q <= 1'b0;
      rd_allow_q <= 1'b0;
      err_q      <= 1'b0;
      wait_cnt_q <= '0;
    end else if (bus_evt) begin
      phase_q    <= PH_PTR;
      rd_allow_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (wr_evt) begin
            if (phase_q == PH_PTR) begin
              phase_q    <= PH_DATA;
              wr_allow_q <= 1'b1;
            end else if (ptr_valid) begin
              wdata_q    <= i2c_rx_data_i;
              wr_allow_q <= 1'b1;
            end else begin
              wr_allow_q <= 1'b0;
              err_q      <= 1'b1;
            end
          end else if (rd_evt) begin
            rd_allow_q <= 1'b0;
            if (!ptr_valid) begin
              tx_data_q <= NACK_FILL;
              err_q     <= 1'b1;
            end
          end
        end
        ST_RD_ISSUE: wait_cnt_q <= '0;
        ST_RD_WAIT: begin
          if (reg_rvalid_i) begin
            tx_data_q  <= reg_rdata_i;
            rd_allow_q <= 1'b1;
          end else if (rd_timeout) begin
            tx_data_q  <= NACK_FILL;
            rd_allow_q <= 1'b0;
            err_q      <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign i2c_tx_data_o = tx_data_q;
  assign wr_allow_o    = wr_allow_q;
  assign rd_allow_o    = rd_allow_q;
  assign err_o         = err_q;
  assign ptr_o         = ptr;

endmodule

// File: tb/tb_i2c_reg_access_ctrl.sv
// Bench for i2c_reg_access_ctrl: two instances (256 and 64 registers) share
// one bus stimulus and are compared against a transaction-level model.
module tb_i2c_reg_access_ctrl;

  localparam int N0  = 256;
  localparam int N1  = 64;
  localparam int TMO = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1, start = 1'b0, stop = 1'b0, match = 1'b0, rw = 1'b0;
  logic       wr_req = 1'b0, rd_req = 1'b0, ai = 1'b0;
  logic [7:0] rx = 8'h00;

  logic [7:0] tx_o[2], addr_o[2], wdata_o[2], ptr_o[2], rdata[2];
  logic       wa_o[2], ra_o[2], we_o[2], re_o[2], err_o[2], rvalid[2];

  i2c_reg_access_ctrl #(.NUM_REGS(N0), .ADDR_W(8), .RD_TIMEOUT(TMO)) dut0 (
    .clk_i(clk), .rst_i(rst), .start_detected_i(start), .stop_detected_i(stop),
    .addr_match_i(match), .rw_bit_i(rw), .wr_req_i(wr_req), .rd_req_i(rd_req),
    .i2c_rx_data_i(rx), .i2c_tx_data_o(tx_o[0]), .wr_allow_o(wa_o[0]),
    .rd_allow_o(ra_o[0]), .auto_inc_i(ai), .reg_addr_o(addr_o[0]),
    .reg_wdata_o(wdata_o[0]), .reg_we_o(we_o[0]), .reg_re_o(re_o[0]),
    .reg_rdata_i(rdata[0]), .reg_rvalid_i(rvalid[0]), .ptr_o(ptr_o[0]), .err_o(err_o[0]));

  i2c_reg_access_ctrl #(.NUM_REGS(N1), .ADDR_W(8), .RD_TIMEOUT(TMO)) dut1 (
    .clk_i(clk), .rst_i(rst), .start_detected_i(start), .stop_detected_i(stop),
    .addr_match_i(match), .rw_bit_i(rw), .wr_req_i(wr_req), .rd_req_i(rd_req),
    .i2c_rx_data_i(rx), .i2c_tx_data_o(tx_o[1]), .wr_allow_o(wa_o[1]),
    .rd_allow_o(ra_o[1]), .auto_inc_i(ai), .reg_addr_o(addr_o[1]),
    .reg_wdata_o(wdata_o[1]), .reg_we_o(we_o[1]), .reg_re_o(re_o[1]),
    .reg_rdata_i(rdata[1]), .reg_rvalid_i(rvalid[1]), .ptr_o(ptr_o[1]), .err_o(err_o[1]));

  // Register bank contents (environment) and read responder.
  logic [7:0] bank[2][256];
  logic       rv_r[2]    = '{1'b0, 1'b0};
  logic [7:0] rd_r[2]    = '{8'h00, 8'h00};
  logic [7:0] raddr[2]   = '{8'h00, 8'h00};
  bit         pend[2]    = '{1'b0, 1'b0};
  int         dly[2]     = '{0, 0};
  bit         rsp_en     = 1'b1;
  int         rsp_lat    = 2;
  bit         man_rv     = 1'b0;

  assign rvalid[0] = rv_r[0] | man_rv;
  assign rvalid[1] = rv_r[1] | man_rv;
  assign rdata[0]  = man_rv ? 8'h99 : rd_r[0];
  assign rdata[1]  = man_rv ? 8'h99 : rd_r[1];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      rv_r[i] = 1'b0;
      if (re_o[i]) begin
        pend[i]  = 1'b1;
        dly[i]   = rsp_lat;
        raddr[i] = addr_o[i];
      end else if (pend[i]) begin
        if (dly[i] <= 1) begin
          pend[i] = 1'b0;
          if (rsp_en) begin
            rv_r[i] = 1'b1;
            rd_r[i] = bank[i][raddr[i]];
          end
        end else begin
          dly[i]--;
        end
      end
    end
  end

  // Strobe monitor.
  int         we_cnt[2] = '{0, 0};
  int         re_cnt[2] = '{0, 0};
  int         both_cnt  = 0;
  logic [7:0] we_addr[2], we_data[2], re_addr[2];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (we_o[i]) begin
        we_cnt[i]++;
        we_addr[i] = addr_o[i];
        we_data[i] = wdata_o[i];
      end
      if (re_o[i]) begin
        re_cnt[i]++;
        re_addr[i] = addr_o[i];
      end
      if (we_o[i] && re_o[i]) both_cnt++;
    end
  end

  // Transaction-level reference model.
  int         nregs[2]   = '{N0, N1};
  int         m_ptr[2];
  bit         m_data[2];
  logic       m_err[2], m_wa[2], m_ra[2];
  logic [7:0] m_tx[2];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_ptr[i] = 0; m_data[i] = 1'b0; m_err[i] = 1'b0;
      m_wa[i] = 1'b0; m_ra[i] = 1'b0; m_tx[i] = 8'h00;
    end
  endtask

  task automatic model_bus_evt();
    for (int i = 0; i < 2; i++) begin
      m_data[i] = 1'b0;
      m_ra[i]   = 1'b0;
    end
  endtask

  task automatic check_outputs(input string tag);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s/u%0d ptr", tag, i), 32'(ptr_o[i]), 32'(m_ptr[i]));
      check($sformatf("%s/u%0d err", tag, i), 32'(err_o[i]), 32'(m_err[i]));
      check($sformatf("%s/u%0d wr_allow", tag, i), 32'(wa_o[i]), 32'(m_wa[i]));
      check($sformatf("%s/u%0d rd_allow", tag, i), 32'(ra_o[i]), 32'(m_ra[i]));
      check($sformatf("%s/u%0d tx", tag, i), 32'(tx_o[i]), 32'(m_tx[i]));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    model_reset();
  endtask

  task automatic bus_start();
    start = 1'b1; tick(); start = 1'b0; tick();
    model_bus_evt();
  endtask

  task automatic bus_stop();
    stop = 1'b1; tick(); stop = 1'b0; tick();
    model_bus_evt();
  endtask

  task automatic wr_byte(input logic [7:0] b, input string tag);
    int   wc[2];
    bit   exp_we[2];
    int   exp_a[2];
    for (int i = 0; i < 2; i++) wc[i] = we_cnt[i];
    rx = b; wr_req = 1'b1;
    tick(); tick(); tick();
    wr_req = 1'b0;
    tick(); tick();
    for (int i = 0; i < 2; i++) begin
      exp_we[i] = 1'b0;
      exp_a[i]  = 0;
      if (match && !rw) begin
        if (!m_data[i]) begin
          m_ptr[i] = int'(b); m_data[i] = 1'b1; m_wa[i] = 1'b1;
        end else if (m_ptr[i] < nregs[i]) begin
          exp_we[i] = 1'b1; exp_a[i] = m_ptr[i]; m_wa[i] = 1'b1;
          if (ai) m_ptr[i] = (m_ptr[i] + 1) % nregs[i];
        end else begin
          m_wa[i] = 1'b0; m_err[i] = 1'b1;
        end
      end
      check($sformatf("%s/u%0d we_count", tag, i), 32'(we_cnt[i] - wc[i]), 32'(exp_we[i]));
      if (exp_we[i]) begin
        check($sformatf("%s/u%0d we_addr", tag, i), 32'(we_addr[i]), 32'(exp_a[i]));
        check($sformatf("%s/u%0d we_data", tag, i), 32'(we_data[i]), 32'(b));
      end
    end
    check_outputs(tag);
  endtask

  task automatic rd_byte(input string tag);
    int rc[2];
    bit exp_re[2];
    int exp_a[2];
    for (int i = 0; i < 2; i++) rc[i] = re_cnt[i];
    rd_req = 1'b1;
    for (int k = 0; k < 8; k++) tick();
    rd_req = 1'b0;
    tick(); tick();
    for (int i = 0; i < 2; i++) begin
      exp_re[i] = 1'b0;
      exp_a[i]  = 0;
      if (match && rw) begin
        if (m_ptr[i] < nregs[i]) begin
          exp_re[i] = 1'b1; exp_a[i] = m_ptr[i];
          m_tx[i] = bank[i][m_ptr[i]]; m_ra[i] = 1'b1;
          if (ai) m_ptr[i] = (m_ptr[i] + 1) % nregs[i];
        end else begin
          m_tx[i] = 8'hFF; m_ra[i] = 1'b0; m_err[i] = 1'b1;
        end
      end
      check($sformatf("%s/u%0d re_count", tag, i), 32'(re_cnt[i] - rc[i]), 32'(exp_re[i]));
      if (exp_re[i]) check($sformatf("%s/u%0d re_addr", tag, i), 32'(re_addr[i]), 32'(exp_a[i]));
    end
    check_outputs(tag);
  endtask

  initial begin
    int rc[2];
    int wc[2];
    int k;
    int nb;

    for (int i = 0; i < 2; i++)
      for (int a = 0; a < 256; a++) bank[i][a] = 8'($urandom_range(0, 255));

    // Reset state.
    do_reset();
    check_outputs("reset");
    for (int i = 0; i < 2; i++) begin
      check($sformatf("reset/u%0d we", i), 32'(we_o[i]), 32'd0);
      check($sformatf("reset/u%0d addr", i), 32'(addr_o[i]), 32'd0);
    end

    // Pointer 0x06 then two data bytes with auto-increment.
    match = 1'b1; rw = 1'b0; ai = 1'b1;
    bus_start();
    wr_byte(8'h06, "wr_ptr06");
    wr_byte(8'hAA, "wr_AA");
    wr_byte(8'h55, "wr_55");
    check("wr_seq final ptr", 32'(ptr_o[0]), 32'h08);

    // Pointer wrap at the last register, then no increment.
    bus_start();
    wr_byte(8'hFF, "wrap_ptr");
    wr_byte(8'h12, "wrap_data");
    check("wrap ptr_o", 32'(ptr_o[0]), 32'h00);
    ai = 1'b0;
    bus_start();
    wr_byte(8'hFF, "noinc_ptr");
    wr_byte(8'h12, "noinc_data");
    check("noinc ptr_o", 32'(ptr_o[0]), 32'hFF);

    // Pointer write, repeated START, read 0x3C.
    ai = 1'b1;
    bus_start();
    wr_byte(8'h10, "rs_ptr");
    bank[0][8'h10] = 8'h3C;
    bank[1][8'h10] = 8'h3C;
    rw = 1'b1;
    bus_start();
    rd_byte("rs_read");
    check("rs_read tx", 32'(tx_o[0]), 32'h3C);
    rd_byte("rs_read2");

    // Out-of-range pointer on the 64-register instance.
    rw = 1'b0;
    bus_start();
    wr_byte(8'h50, "oor_ptr");
    wr_byte(8'h01, "oor_data");
    check("oor u1 wr_allow", 32'(wa_o[1]), 32'd0);

    // Write edge coinciding with START is dropped.
    bus_start();
    for (int i = 0; i < 2; i++) wc[i] = we_cnt[i];
    rx = 8'h77; wr_req = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    wr_req = 1'b0;
    tick(); tick();
    model_bus_evt();
    for (int i = 0; i < 2; i++)
      check($sformatf("drop/u%0d we_count", i), 32'(we_cnt[i] - wc[i]), 32'd0);
    check_outputs("drop");
    wr_byte(8'h20, "after_drop_ptr");

    // Edges with no address match are ignored.
    match = 1'b0;
    wr_byte(8'h33, "nomatch");
    match = 1'b1;

    // Randomized transactions.
    for (int it = 0; it < 10; it++) begin
      ai    = 1'($urandom_range(0, 1));
      match = ($urandom_range(0, 4) != 0);
      rw    = 1'b0;
      bus_start();
      wr_byte(8'($urandom_range(0, 255)), $sformatf("rnd%0d_ptr", it));
      nb = int'($urandom_range(0, 2));
      for (int j = 0; j < nb; j++)
        wr_byte(8'($urandom_range(0, 255)), $sformatf("rnd%0d_wr%0d", it, j));
      rw = 1'b1;
      bus_start();
      nb = int'($urandom_range(1, 2));
      for (int j = 0; j < nb; j++) rd_byte($sformatf("rnd%0d_rd%0d", it, j));
      bus_stop();
    end
    match = 1'b1;

    // Read timeout: no valid ever comes back.
    do_reset();
    ai = 1'b1; rw = 1'b1; rsp_en = 1'b0;
    bus_start();
    for (int i = 0; i < 2; i++) rc[i] = re_cnt[i];
    rd_req = 1'b1;
    k = 0;
    while (k <= 40 && err_o[0] !== 1'b1) begin
      tick();
      k++;
    end
    check("tmo latency", 32'(k), 32'(TMO + 2));
    rd_req = 1'b0;
    tick(); tick();
    for (int i = 0; i < 2; i++) begin
      m_tx[i] = 8'hFF; m_ra[i] = 1'b0; m_err[i] = 1'b1;
      check($sformatf("tmo/u%0d re_count", i), 32'(re_cnt[i] - rc[i]), 32'd1);
    end
    check_outputs("tmo");
    rsp_en = 1'b1;

    // STOP during read wait, then a late valid is ignored.
    rd_byte("pre_stop_read");
    rsp_en = 1'b0;
    for (int i = 0; i < 2; i++) rc[i] = re_cnt[i];
    rd_req = 1'b1;
    tick(); tick(); tick();
    stop = 1'b1; tick(); stop = 1'b0;
    man_rv = 1'b1; tick(); man_rv = 1'b0;
    rd_req = 1'b0;
    tick(); tick();
    model_bus_evt();
    for (int i = 0; i < 2; i++)
      check($sformatf("stop/u%0d re_count", i), 32'(re_cnt[i] - rc[i]), 32'd1);
    check_outputs("stop_late_valid");
    rsp_en = 1'b1;
    rd_byte("post_stop_read");

    // Reset while a write commit is in flight.
    rw = 1'b0;
    bus_start();
    wr_byte(8'h05, "rst_ptr");
    for (int i = 0; i < 2; i++) wc[i] = we_cnt[i];
    rx = 8'hC3; wr_req = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    wr_req = 1'b0;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst_mid/u%0d we_count", i), 32'(we_cnt[i] - wc[i]), 32'd0);
      check($sformatf("rst_mid/u%0d wdata", i), 32'(wdata_o[i]), 32'd0);
      check($sformatf("rst_mid/u%0d re", i), 32'(re_o[i]), 32'd0);
    end
    check_outputs("rst_mid");
    tick();
    rst = 1'b0;
    tick(); tick();
    check_outputs("rst_mid_after");

    check("we_re overlap count", 32'(both_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_reg_access_ctrl.md
Name: i2c_reg_access_ctrl

Overview:
- Sequences register-bank access for the I2C slave interface in the 16-channel PWM design.
- Converts the slave's byte-level requests into register-bank reads and writes:
  - first written byte after an address match is the register pointer;
  - later bytes go to reg[ptr], with optional pointer auto-increment.
- Drives the slave's wr_allow/rd_allow (ACK) and tx-data inputs.
- Sits between i2c_slave_interface and the PWM register file.

Parameters:
- NUM_REGS, 256, number of implemented register addresses (0..NUM_REGS-1).
- ADDR_W, 8, register address width.
- RD_TIMEOUT, 15, max clk cycles to wait for reg_rvalid_i before abandoning a read.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous, active-high reset
- start_detected_i  in  1  START/repeated-START pulse from detector
- stop_detected_i  in  1  STOP pulse from detector
- addr_match_i  in  1  slave address matched
- rw_bit_i  in  1  0=master write, 1=master read
- wr_req_i  in  1  slave holds a received byte (level; act on rising edge)
- rd_req_i  in  1  slave needs a tx byte (level; act on rising edge)
- i2c_rx_data_i  in  8  byte received from master
- i2c_tx_data_o  out  8  byte for slave to shift out
- wr_allow_o  out  1  1=ACK written byte, 0=NACK
- rd_allow_o  out  1  1=tx byte valid
- auto_inc_i  in  1  pointer auto-increment enable (MODE1.AI)
- reg_addr_o  out  ADDR_W  register address
- reg_wdata_o  out  8  write data
- reg_we_o  out  1  one-cycle write strobe
- reg_re_o  out  1  one-cycle read strobe
- reg_rdata_i  in  8  read data
- reg_rvalid_i  in  1  read data valid (>=1 cycle after reg_re_o)
- ptr_o  out  ADDR_W  current register pointer (debug/status)
- err_o  out  1  sticky error: write to/read from invalid address, or read timeout

Behaviour:
- Reset (rst_i=1 at posedge clk_i): every output is 0, including i2c_tx_data_o=8'h00 and ptr_o=0. FSM goes to IDLE and phase to PTR.
- Edge detect: wr_req_i and rd_req_i are registered. The event is req & ~req_q, one cycle after the rising edge.
- FSM states: IDLE, WR_COMMIT, RD_ISSUE, RD_WAIT. Phase flag PTR/DATA qualifies writes.
- Priority, per cycle: rst_i > stop_detected_i > start_detected_i > request edges. An edge arriving in the same cycle as start or stop is dropped.
- start_detected_i:
  - phase<=PTR, FSM->IDLE, rd_allow_o<=0;
  - ptr is retained, so a repeated-START read continues from the last pointer.
- stop_detected_i:
  - FSM->IDLE, phase<=PTR, rd_allow_o<=0, no strobes;
  - a pending read is abandoned; a late reg_rvalid_i is ignored.
- Write edge in IDLE with addr_match_i=1 and rw_bit_i=0:
  - phase PTR: ptr<=i2c_rx_data_i, phase<=DATA, wr_allow_o<=1. No reg_we_o.
  - phase DATA with ptr<NUM_REGS: go to WR_COMMIT. The next cycle gives reg_we_o=1, reg_addr_o=ptr, reg_wdata_o=i2c_rx_data_i, wr_allow_o=1. If auto_inc_i, ptr<=ptr+1, wrapping NUM_REGS-1 -> 0. Then IDLE.
  - phase DATA with ptr>=NUM_REGS: wr_allow_o<=0 (NACK), err_o<=1, no write.
- Timing: wr_allow_o settles within 2 clk of the wr_req_i rise, well before the next SCL fall.
- Read edge in IDLE with addr_match_i=1 and rw_bit_i=1:
  - ptr<NUM_REGS: go to RD_ISSUE, which gives reg_re_o=1 for one cycle with reg_addr_o=ptr, then RD_WAIT.
  - ptr>=NUM_REGS: i2c_tx_data_o<=8'hFF, rd_allow_o<=0, err_o<=1.
  - rd_allow_o is cleared on the rd_req_i edge.
- RD_WAIT:
  - on reg_rvalid_i: i2c_tx_data_o<=reg_rdata_i, rd_allow_o<=1, ptr increments as for writes, then IDLE;
  - after RD_TIMEOUT cycles with no reg_rvalid_i: i2c_tx_data_o<=8'hFF, rd_allow_o=0, err_o<=1, IDLE, ptr unchanged.
- Edges with addr_match_i=0 are ignored.
- Edges arriving outside IDLE are ignored; the bus rate guarantees they do not occur.
- reg_we_o and reg_re_o are never high together.
- err_o clears only on rst_i.

Decomposition:
- Package i2c_pkg holds:
  - FSM state localparams;
  - PTR/DATA phase encoding;
  - NACK_FILL=8'hFF;
  - default NUM_REGS and ADDR_W.
- One sub-module, i2c_reg_ptr: pointer register with load, auto-increment and wrap at NUM_REGS-1, plus a valid flag (ptr<NUM_REGS).

Test Plan:
- Write 0x06 then 0xAA, 0x55 with auto_inc_i=1 -> reg_we_o at addr 0x06 with data 0xAA, then at 0x07 with 0x55; ptr_o=0x08; wr_allow_o=1 throughout.
- ptr=0xFF (NUM_REGS=256), write 0x12 with auto_inc_i=1 -> write at 0xFF, ptr_o wraps to 0x00; with auto_inc_i=0, ptr_o stays 0xFF.
- Write pointer 0x10, repeated START, read with reg_rdata_i=0x3C after 2 cycles -> reg_re_o at 0x10, i2c_tx_data_o=0x3C, rd_allow_o=1, ptr_o=0x11.
- NUM_REGS=64, pointer 0x50, data byte 0x01 -> wr_allow_o=0, no reg_we_o, err_o=1.
- Read with reg_rvalid_i never asserted -> after 15 cycles i2c_tx_data_o=0xFF, rd_allow_o=0, err_o=1.
- STOP during RD_WAIT, then late reg_rvalid_i -> FSM IDLE, rd_allow_o=0, i2c_tx_data_o unchanged. rst_i mid-WR_COMMIT -> no reg_we_o, all outputs 0.
